// File: rtl/seg7_pair_receiver_if.sv
// Pin/result bundle between a dual seven-segment display driver and its loopback receiver.
interface seg7_pair_receiver_if;
  logic       i_Segment1_A, i_Segment1_B, i_Segment1_C, i_Segment1_D;
  logic       i_Segment1_E, i_Segment1_F, i_Segment1_G;
  logic       i_Segment2_A, i_Segment2_B, i_Segment2_C, i_Segment2_D;
  logic       i_Segment2_E, i_Segment2_F, i_Segment2_G;
  logic [3:0] o_Digit1, o_Digit2;
  logic       o_Valid, o_Error;

  modport master (
    output i_Segment1_A, i_Segment1_B, i_Segment1_C, i_Segment1_D,
           i_Segment1_E, i_Segment1_F, i_Segment1_G,
           i_Segment2_A, i_Segment2_B, i_Segment2_C, i_Segment2_D,
           i_Segment2_E, i_Segment2_F, i_Segment2_G,
    input  o_Digit1, o_Digit2, o_Valid, o_Error
  );

  modport slave (
    input  i_Segment1_A, i_Segment1_B, i_Segment1_C, i_Segment1_D,
           i_Segment1_E, i_Segment1_F, i_Segment1_G,
           i_Segment2_A, i_Segment2_B, i_Segment2_C, i_Segment2_D,
           i_Segment2_E, i_Segment2_F, i_Segment2_G,
    output o_Digit1, o_Digit2, o_Valid, o_Error
  );
endinterface

// File: rtl/seg7_pair_receiver.sv
// Dual seven-segment receiver: synchronise, wait for a stable pattern, decode to hex.
// Define SEG7_RX_STICKY_ERR_EN to make o_Error hold until reset instead of pulsing.
module seg7_digit_dec (
  input  logic [6:0] seg,
  output logic [3:0] val,
  output logic       ok
);
  always_comb begin
    val = 4'h0;
    ok  = 1'b1;
    case (seg)
      7'h3F: val = 4'h0;
      7'h06: val = 4'h1;
      7'h5B: val = 4'h2;
      7'h4F: val = 4'h3;
      7'h66: val = 4'h4;
      7'h6D: val = 4'h5;
      7'h7D: val = 4'h6;
      7'h07: val = 4'h7;
      7'h7F: val = 4'h8;
      7'h6F: val = 4'h9;
      7'h77: val = 4'hA;
      7'h7C: val = 4'hB;
      7'h39: val = 4'hC;
      7'h5E: val = 4'hD;
      7'h79: val = 4'hE;
      7'h71: val = 4'hF;
      default: ok = 1'b0;
    endcase
  end
endmodule

module seg7_pair_receiver #(
  parameter int STABLE_CYCLES = 16
) (
  input  logic                i_Clk,
  input  logic                i_Rst_L,
  seg7_pair_receiver_if.slave bus
);
  localparam int NUM_LANES = 2;
  localparam int SEG_W     = 7;
  localparam int CNT_W     = $clog2(STABLE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETTLE = 2'd1;
  localparam logic [1:0] COMMIT = 2'd2;

  logic [NUM_LANES-1:0][SEG_W-1:0] pin_raw, sync1, sync2, p, p_prev, p_acc;
  logic [NUM_LANES-1:0][3:0]       dec_val, digit_q;
  logic [NUM_LANES-1:0]            dec_ok;
  logic [1:0]                      state;
  logic [CNT_W-1:0]                cnt;
  logic                            valid_q, err_q;

  assign pin_raw[0] = {bus.i_Segment1_G, bus.i_Segment1_F, bus.i_Segment1_E, bus.i_Segment1_D,
                       bus.i_Segment1_C, bus.i_Segment1_B, bus.i_Segment1_A};
  assign pin_raw[1] = {bus.i_Segment2_G, bus.i_Segment2_F, bus.i_Segment2_E, bus.i_Segment2_D,
                       bus.i_Segment2_C, bus.i_Segment2_B, bus.i_Segment2_A};

  // Synchronisers reset to all-high so the post-reset pattern reads as blank (== p_acc).
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= pin_raw;
      sync2 <= sync1;
    end
  end

  assign p = ~sync2;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    seg7_digit_dec u_dec (
      .seg (p_prev[g]),
      .val (dec_val[g]),
      .ok  (dec_ok[g])
    );
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state   <= IDLE;
      cnt     <= '0;
      p_prev  <= '0;
      p_acc   <= '0;
      digit_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
`ifndef SEG7_RX_STICKY_ERR_EN
      err_q   <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (p != p_acc) begin
            p_prev <= p;
            cnt    <= CNT_W'(1);
            state  <= SETTLE;
          end
        end
        SETTLE: begin
          if (p != p_prev) begin
            p_prev <= p;
            cnt    <= CNT_W'(1);
          end else if (cnt == CNT_MAX) begin
            state <= COMMIT;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        COMMIT: begin
          // Re-committing p_acc is deliberate: a settle back to it re-issues the strobe.
          p_acc <= p_prev;
          cnt   <= '0;
          state <= IDLE;
          if (&dec_ok) begin
            digit_q <= dec_val;
            valid_q <= 1'b1;
          end else begin
            err_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.o_Digit1 = digit_q[0];
  assign bus.o_Digit2 = digit_q[1];
  assign bus.o_Valid  = valid_q;
  assign bus.o_Error  = err_q;
endmodule

// File: tb/tb_seg7_pair_receiver.sv
// Scoreboard bench for seg7_pair_receiver: stimulus pushes expected commits, monitor pops on strobes.
module tb_seg7_pair_receiver;
  localparam int STABLE = 16;
  localparam int LAT    = STABLE + 4;   // drive time (cycle n) to observed strobe (negedge after edge n+20)

  typedef struct {
    logic [3:0] d1;
    logic [3:0] d2;
    logic       err;
    int         cyc;
  } exp_t;

  logic i_Clk = 1'b0;
  logic i_Rst_L = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  logic sticky_m = 1'b0;
  logic err_prev = 1'b0;
  exp_t sb[$];

  seg7_pair_receiver_if bus();

  seg7_pair_receiver #(.STABLE_CYCLES(STABLE)) dut (
    .i_Clk   (i_Clk),
    .i_Rst_L (i_Rst_L),
    .bus     (bus)
  );

  always #5 i_Clk = ~i_Clk;
  always @(posedge i_Clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (act === exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic set_pins(input logic [6:0] c1, input logic [6:0] c2);
    logic [6:0] n1, n2;
    n1 = ~c1;
    n2 = ~c2;
    {bus.i_Segment1_G, bus.i_Segment1_F, bus.i_Segment1_E, bus.i_Segment1_D,
     bus.i_Segment1_C, bus.i_Segment1_B, bus.i_Segment1_A} = n1;
    {bus.i_Segment2_G, bus.i_Segment2_F, bus.i_Segment2_E, bus.i_Segment2_D,
     bus.i_Segment2_C, bus.i_Segment2_B, bus.i_Segment2_A} = n2;
  endtask

  task automatic push(input logic [3:0] d1, input logic [3:0] d2, input logic err);
    exp_t e;
    e.d1 = d1; e.d2 = d2; e.err = err; e.cyc = cyc + LAT;
    sb.push_back(e);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_digit1"}, 32'(bus.o_Digit1), 32'h0);
    chk({tag, "_digit2"}, 32'(bus.o_Digit2), 32'h0);
    chk({tag, "_valid"},  32'(bus.o_Valid),  32'h0);
    chk({tag, "_error"},  32'(bus.o_Error),  32'h0);
  endtask

  // Monitor: every strobe must match the oldest outstanding expectation.
  always @(negedge i_Clk) begin
    if (!i_Rst_L) begin
      err_prev = 1'b0;
    end else begin
`ifndef SEG7_RX_STICKY_ERR_EN
      if (bus.o_Error) chk("err_one_cycle", 32'(err_prev), 32'h0);
`endif
      if (bus.o_Valid || (bus.o_Error && !err_prev)) begin
        if (sb.size() == 0) begin
          chk("unexpected_strobe", 32'(bus.o_Valid), 32'(bus.o_Valid ^ 1'b1));
        end else begin
          exp_t e;
          logic exp_err;
          e = sb.pop_front();
`ifdef SEG7_RX_STICKY_ERR_EN
          exp_err = e.err | sticky_m;
          if (e.err) sticky_m = 1'b1;
`else
          exp_err = e.err;
`endif
          chk("latency", 32'(cyc),          32'(e.cyc));
          chk("valid",   32'(bus.o_Valid),  32'(!e.err));
          chk("error",   32'(bus.o_Error),  32'(exp_err));
          chk("digit1",  32'(bus.o_Digit1), 32'(e.d1));
          chk("digit2",  32'(bus.o_Digit2), 32'(e.d2));
        end
      end
      err_prev = bus.o_Error;
    end
  end

  initial begin
    set_pins(7'h00, 7'h00);
    repeat (5) @(posedge i_Clk);
    #1 chk_zero("in_reset");
    i_Rst_L = 1'b1;

    // Blank display after reset: no event at all.
    repeat (100) @(posedge i_Clk);
    @(negedge i_Clk);
    chk_zero("blank_idle");

    // "3" / "A"
    @(posedge i_Clk); #1;
    set_pins(7'h4F, 7'h77);
    push(4'h3, 4'hA, 1'b0);
    repeat (30) @(posedge i_Clk);

    // Segment D of digit 1 chatters, then settles back to the accepted pattern.
    for (int i = 0; i < 10; i++) begin
      @(posedge i_Clk); #1;
      bus.i_Segment1_D = logic'(i % 2);
    end
    @(posedge i_Clk); #1;
    bus.i_Segment1_D = 1'b0;
    push(4'h3, 4'hA, 1'b0);
    repeat (30) @(posedge i_Clk);

    // Segment A only on digit 1: unrecognised, digits held.
    @(posedge i_Clk); #1;
    set_pins(7'h01, 7'h77);
    push(4'h3, 4'hA, 1'b1);
    repeat (30) @(posedge i_Clk);

    // "7" / "F"
    @(posedge i_Clk); #1;
    set_pins(7'h07, 7'h71);
    push(4'h7, 4'hF, 1'b0);
    repeat (30) @(posedge i_Clk);

    // "4" / "1" interrupted by reset mid-settle, then held through release.
    @(posedge i_Clk); #1;
    set_pins(7'h66, 7'h06);
    repeat (9) @(posedge i_Clk);
    #1 i_Rst_L = 1'b0;
    sticky_m = 1'b0;
    #1 chk_zero("mid_reset");
    repeat (3) @(posedge i_Clk);
    #1 i_Rst_L = 1'b1;
    push(4'h4, 4'h1, 1'b0);
    repeat (30) @(posedge i_Clk);

    chk("outstanding_commits", 32'(sb.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
